// File: rtl/mul4_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul4_seq
//  Description : 4x4 unsigned sequential shift-add multiplier. One operand
//                pair is captured on start, four BUSY iterations produce the
//                8-bit product, then a one-cycle DONE state pulses done.
//                Optional build macro MUL4_SEQ_ZERO_SKIP_EN: a start with a
//                zero operand bypasses BUSY and goes straight to DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] c_LAST_ITER = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_mcand;
    logic [7:0]  r_p;
    logic [1:0]  r_cnt;
    logic [7:0]  r_product;

    logic [4:0]  w_sum;
    logic [7:0]  w_p_next;
    logic        w_last;
    logic        w_zero_skip;

    // One shift-add step: the upper half of P accumulates the multiplicand
    // (with carry kept as the new MSB) when the current multiplier bit is set.
    always_comb begin
        w_sum    = {1'b0, r_p[7:4]} + {1'b0, r_mcand};
        w_p_next = r_p[0] ? {w_sum, r_p[3:1]} : {1'b0, r_p[7:1]};
        w_last   = (r_cnt == c_LAST_ITER);
`ifdef MUL4_SEQ_ZERO_SKIP_EN
        w_zero_skip = (a == 4'd0) || (b == 4'd0);
`else
        w_zero_skip = 1'b0;
`endif
    end

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_zero_skip ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operands are captured only on an accepted start, so later
    // changes on a/b cannot disturb the operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= 4'd0;
            r_p       <= 8'd0;
            r_cnt     <= 2'd0;
            r_product <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_p     <= {4'b0000, b};
                        r_cnt   <= 2'd0;
                        if (w_zero_skip) begin
                            r_product <= 8'd0;
                        end
                    end
                end
                S_BUSY: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + 2'd1;
                    if (w_last) begin
                        r_product <= w_p_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire
